// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_pkg
//  Description : Shared definitions for the JPEG byte stuffer: emitter state
//                encoding, JPEG marker/stuff byte constants, the byte-count
//                width and a word-to-byte selection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

    // Width of the running and per-frame byte counters.
    localparam int BYTE_CNT_W = 32;

    // Marker and stuffing bytes.
    localparam logic [7:0] MARKER_FF = 8'hFF;
    localparam logic [7:0] STUFF_00  = 8'h00;
    localparam logic [7:0] MARKER_D9 = 8'hD9;

    // Emitter state: names what the output register currently presents.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_STUFF  = 3'd2,
        S_EOI_FF = 3'd3,
        S_EOI_D9 = 3'd4
    } state_t;

    // Byte idx of a word in stream order: idx 0 is [31:24], idx 3 is [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] w,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage : jpeg_pkg
`default_nettype wire

// File: rtl/jpeg_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_word_fifo
//  Description : 32-bit synchronous FIFO with first-word fall-through read
//                data. Writes while full and reads while empty are ignored.
//  Ports       : clk_i, rst_n_i (async, active-low)
//                wr_data/wr_en  - push side
//                rd_en/rd_data  - pop side (rd_data is the current head)
//                full/empty     - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule : jpeg_word_fifo
`default_nettype wire

// File: rtl/jpeg_byte_stuffer.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_byte_stuffer
//  Description : Serialises 32-bit entropy-coded words into JFIF scan bytes,
//                inserting a 00 after every FF data byte, and terminates a
//                frame with an unstuffed FFD9 marker on request. Counts the
//                bytes of each frame.
//  Ports       : clk_i, rst_n_i       - clock, async active-low reset
//                word_i/word_valid_i/word_ready_o - word input handshake
//                eoi_req_i            - one-cycle end-of-image request
//                byte_o/byte_valid_o/byte_ready_i - byte output handshake
//                eoi_done_o           - pulse the cycle after D9 is taken
//                frame_bytes_o        - byte count of last completed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_byte_stuffer
    import jpeg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [31:0]           word_i,
    input  logic                  word_valid_i,
    output logic                  word_ready_o,
    input  logic                  eoi_req_i,
    output logic [7:0]            byte_o,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic                  eoi_done_o,
    output logic [BYTE_CNT_W-1:0] frame_bytes_o
);

    state_t                  state;
    state_t                  next_state;

    logic [31:0]             cur_word;
    logic [1:0]              cur_idx;
    logic [31:0]             next_word;
    logic [1:0]              next_idx;
    logic [7:0]              next_byte;
    logic                    next_valid;

    logic                    eoi_pending;
    logic [BYTE_CNT_W-1:0]   byte_cnt;

    logic [31:0]             fifo_rd_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic                    accept;
    logic                    step_data;
    logic                    word_done;
    logic                    d9_accept;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    assign word_ready_o = !fifo_full && !eoi_pending;
    assign fifo_push    = word_valid_i && word_ready_o;

    jpeg_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .wr_data (word_i),
        .wr_en   (fifo_push),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign accept    = byte_valid_o && byte_ready_i;
    assign word_done = (cur_idx == 2'd3);
    // The presented data byte is finished with: either a plain data byte
    // was taken, or the 00 following an FF data byte was taken.
    assign step_data = ((state == S_DATA) && accept && (byte_o != MARKER_FF)) ||
                       ((state == S_STUFF) && accept);
    assign d9_accept = (state == S_EOI_D9) && accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    next_state = S_DATA;
                end else if (eoi_pending) begin
                    next_state = S_EOI_FF;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_o == MARKER_FF) begin
                        next_state = S_STUFF;
                    end else if (!word_done || !fifo_empty) begin
                        next_state = S_DATA;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_STUFF: begin
                if (accept) begin
                    if (!word_done || !fifo_empty) begin
                        next_state = S_DATA;
                    end else if (eoi_pending) begin
                        next_state = S_EOI_FF;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_EOI_FF: begin
                if (accept) begin
                    next_state = S_EOI_D9;
                end
            end
            S_EOI_D9: begin
                if (accept) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. The output register is reloaded only
    // when the state moves on, so byte_o holds while the sink stalls.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_pop   = 1'b0;
        next_word  = cur_word;
        next_idx   = cur_idx;
        next_byte  = byte_o;
        next_valid = (next_state != S_IDLE);
        unique case (next_state)
            S_DATA: begin
                if ((state == S_IDLE) || (step_data && word_done)) begin
                    // Start a fresh word straight from the FIFO head.
                    fifo_pop  = 1'b1;
                    next_word = fifo_rd_data;
                    next_idx  = 2'd0;
                    next_byte = fifo_rd_data[31:24];
                end else if (step_data) begin
                    next_idx  = cur_idx + 2'd1;
                    next_byte = word_byte(cur_word, cur_idx + 2'd1);
                end
            end
            S_STUFF:  next_byte = STUFF_00;
            S_EOI_FF: next_byte = MARKER_FF;
            S_EOI_D9: next_byte = MARKER_D9;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            byte_o       <= 8'h00;
            byte_valid_o <= 1'b0;
            cur_word     <= 32'h0;
            cur_idx      <= 2'd0;
        end else begin
            byte_o       <= next_byte;
            byte_valid_o <= next_valid;
            cur_word     <= next_word;
            cur_idx      <= next_idx;
        end
    end

    // ------------------------------------------------------------------
    // EOI tracking and frame byte counting. eoi_pending drops on the same
    // edge that raises eoi_done_o, so the idle state never sees a stale
    // request and word input reopens during the done pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            eoi_pending   <= 1'b0;
            eoi_done_o    <= 1'b0;
            byte_cnt      <= '0;
            frame_bytes_o <= '0;
        end else begin
            eoi_done_o <= d9_accept;
            if (d9_accept) begin
                eoi_pending <= 1'b0;
            end else if (eoi_req_i) begin
                eoi_pending <= 1'b1;
            end
            if (d9_accept) begin
                frame_bytes_o <= byte_cnt + 1'b1;
                byte_cnt      <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule : jpeg_byte_stuffer
`default_nettype wire

// File: doc/jpeg_byte_stuffer.md
JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): depth of the input word FIFO.
REQ-002 SHALL have port clk_i, input, 1: single clock; same domain as the encoder output (clk_x8_i at top level).
REQ-003 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port word_i, input, 32: encoded entropy word from encode; [31:24] is the first byte in the stream.
REQ-005 SHALL have port word_valid_i, input, 1: word_i is valid.
REQ-006 SHALL have port word_ready_o, output, 1: a word is accepted on a cycle where word_valid_i and word_ready_o are both high.
REQ-007 SHALL have port eoi_req_i, input, 1: one-cycle request to terminate the frame with an FFD9 marker.
REQ-008 SHALL have port byte_o, output, 8: output JFIF scan byte.
REQ-009 SHALL have port byte_valid_o, output, 1: byte_o is valid.
REQ-010 SHALL have port byte_ready_i, input, 1: sink accepts byte_o on a cycle where byte_valid_o and byte_ready_i are both high.
REQ-011 SHALL have port eoi_done_o, output, 1: one-cycle pulse on the cycle after D9 is accepted.
REQ-012 SHALL have port frame_bytes_o, output, 32: total bytes emitted for the last completed frame, including stuffed 00s and FFD9.

Function
REQ-013 SHALL assert word_ready_o = !fifo_full && !eoi_pending, with no read-through when full.
REQ-014 SHALL emit each word's bytes in the order [31:24], [23:16], [15:8], [7:0], in FIFO order.
REQ-015 SHALL insert one 00 byte immediately after every emitted data byte equal to FF, before the next data byte or marker.
REQ-016 SHALL never stuff the EOI marker bytes FF and D9.
REQ-017 SHALL register byte_o/byte_valid_o and hold byte_o stable while byte_valid_o=1 and byte_ready_i=0.
REQ-018 SHALL sustain one byte per cycle while byte_ready_i=1 and data is available, with no bubble between consecutive words.
REQ-019 SHALL, for a word accepted at cycle N into an empty FIFO with the block idle, present its first byte with byte_valid_o=1 at cycle N+2.
REQ-020 SHALL implement state machine S_IDLE, S_DATA, S_STUFF, S_EOI_FF, S_EOI_D9 with these transitions:
- IDLE->DATA: FIFO not empty.
- IDLE->EOI_FF: eoi_pending and FIFO empty.
- DATA->STUFF: accepted byte == FF.
- DATA->DATA/IDLE: after byte 3, depending on FIFO non-empty.
- STUFF->DATA/IDLE/EOI_FF: after the 00 byte is accepted.
- EOI_FF->EOI_D9->IDLE.
REQ-021 SHALL set eoi_pending on eoi_req_i, and ignore eoi_req_i while it is already set.
REQ-022 SHALL treat a word accepted in the same cycle as eoi_req_i as preceding the EOI marker.
REQ-023 SHALL clear eoi_pending when eoi_done_o pulses.
REQ-024 SHALL count every accepted output byte in a 32-bit running counter, wrapping modulo 2^32.
REQ-025 SHALL, on the cycle D9 is accepted, latch the running counter + 1 into frame_bytes_o and reset the running counter to 0.
REQ-026 SHALL emit FFD9 immediately (byte count 2) when eoi_req_i arrives with the FIFO empty and the block idle.

Reset
REQ-027 SHALL, while rst_n_i=0, asynchronously clear:
- byte_o=00, byte_valid_o=0, eoi_done_o=0, frame_bytes_o=0;
- the running counter, eoi_pending, FIFO pointers;
- the state, to S_IDLE.
REQ-028 SHALL drive word_ready_o=1 on the first cycle after reset release.
REQ-029 SHALL discard FIFO contents and any partially emitted word on reset assertion mid-frame, with no resumption after release.

Structure
REQ-030 SHALL place the state enum, the marker constants (FF, 00, D9) and the byte-count width in shared package jpeg_pkg.
REQ-031 SHALL implement the word FIFO as sub-module jpeg_word_fifo (32-bit wide, FIFO_DEPTH entries, full/empty flags).

Verification
REQ-032 SHALL cover this scenario: words 12345678 then 9ABCDEF0, byte_ready_i=1 -> bytes 12 34 56 78 9A BC DE F0 on consecutive cycles, with the first byte at acceptance+2.
REQ-033 SHALL cover this scenario: word FFFF00FF -> bytes FF 00 FF 00 00 FF 00 (7 bytes).
REQ-034 SHALL cover this scenario: word AABBCCDD, then eoi_req_i -> AA BB CC DD FF D9, then an eoi_done_o pulse and frame_bytes_o=6.
REQ-035 SHALL cover this scenario: byte_ready_i toggling 1/0 every cycle on 5 words -> no byte lost or duplicated, and word_ready_o=0 once FIFO_DEPTH words are queued.
REQ-036 SHALL cover this scenario: eoi_req_i pulsed twice while pending -> exactly one FFD9 is emitted.
REQ-037 SHALL cover this scenario: rst_n_i asserted mid-word -> outputs are at reset values within the same cycle, and a subsequent word 01020304 emits exactly 01 02 03 04.
